// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, coin values and helpers for the vending controller
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        COIN_WAIT    = 3'd1,
        VEND         = 3'd2,
        CHANGE_PULSE = 3'd3,
        CHANGE_GAP   = 3'd4
    } state_e;

    localparam logic [2:0] NICKEL_U  = 3'd1;
    localparam logic [2:0] DIME_U    = 3'd2;
    localparam logic [2:0] QUARTER_U = 3'd5;

    // Zero-extend narrower vectors to 8 bits before calling.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/vend_if.sv
// rtl/vend_if.sv - coin/button inputs and dispenser outputs of the vending controller
interface vend_if #(
    parameter int NUM_PRODUCTS = 2,
    parameter int CREDIT_W     = 5
);
    logic                    nickel;
    logic                    dime;
    logic                    quarter;
    logic [NUM_PRODUCTS-1:0] select;
    logic                    cancel;
    logic [NUM_PRODUCTS-1:0] vend;
    logic                    change;
    logic [CREDIT_W-1:0]     credit;
    logic                    busy;

    modport master (
        output nickel, dime, quarter, select, cancel,
        input  vend, change, credit, busy
    );

    modport slave (
        input  nickel, dime, quarter, select, cancel,
        output vend, change, credit, busy
    );
endinterface

// File: rtl/coin_qualifier.sv
// rtl/coin_qualifier.sv - classifies the coin sensor lines into a credit value or a jam
module coin_qualifier
    import vend_pkg::*;
(
    input  logic       nickel_i,
    input  logic       dime_i,
    input  logic       quarter_i,
    input  logic       enable_i,
    output logic       coin_valid_o,
    output logic [2:0] coin_units_o,
    output logic       jam_o,
    output logic       all_clear_o
);
    logic [7:0] lines;
    logic       single;

    assign lines  = {5'b0, quarter_i, dime_i, nickel_i};
    assign single = is_onehot(lines);

    always_comb begin
        coin_units_o = 3'd0;
        case (lines[2:0])
            3'b001:  coin_units_o = NICKEL_U;
            3'b010:  coin_units_o = DIME_U;
            3'b100:  coin_units_o = QUARTER_U;
            default: coin_units_o = 3'd0;
        endcase
    end

    assign coin_valid_o = enable_i & single;
    // Several lines at once means the coin is stuck across sensors: swallow it.
    assign jam_o        = enable_i & ~single & (|lines);
    assign all_clear_o  = ~(|lines);

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - credit-counting vending FSM with vend, change and refund paths
module vend_controller
    import vend_pkg::*;
#(
    parameter int NUM_PRODUCTS = 2,
    parameter int PRICE        = 9,
    parameter int CREDIT_W     = 5
) (
    input logic   clk,
    input logic   reset,
    vend_if.slave bus
);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_e                  state_q;
    logic [CREDIT_W-1:0]     credit_q;
    logic [NUM_PRODUCTS-1:0] vend_q;
    logic                    change_q;
    logic                    busy_q;

    logic       coin_enable;
    logic       coin_valid;
    logic [2:0] coin_units;
    logic       coin_jam;
    logic       coins_clear;
    logic       sel_valid;

    assign coin_enable = (state_q == IDLE) && (credit_q < PRICE_C);
    assign sel_valid   = (credit_q >= PRICE_C) && is_onehot(8'(bus.select));

    coin_qualifier u_coin_qualifier (
        .nickel_i     (bus.nickel),
        .dime_i       (bus.dime),
        .quarter_i    (bus.quarter),
        .enable_i     (coin_enable),
        .coin_valid_o (coin_valid),
        .coin_units_o (coin_units),
        .jam_o        (coin_jam),
        .all_clear_o  (coins_clear)
    );

    // Outputs are assigned for the state being entered, so they are registered
    // and line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            vend_q   <= '0;
            change_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            vend_q   <= '0;
            change_q <= 1'b0;
            busy_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cancel && (credit_q != '0)) begin
                        state_q  <= CHANGE_PULSE;
                        change_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end else if (sel_valid) begin
                        credit_q <= credit_q - PRICE_C;
                        vend_q   <= bus.select;
                        state_q  <= VEND;
                        busy_q   <= 1'b1;
                    end else if (coin_valid) begin
                        credit_q <= credit_q + CREDIT_W'(coin_units);
                        state_q  <= COIN_WAIT;
                    end else if (coin_jam) begin
                        state_q  <= COIN_WAIT;
                    end
                end
                COIN_WAIT: begin
                    if (coins_clear) begin
                        state_q <= IDLE;
                    end
                end
                VEND: begin
                    if (credit_q != '0) begin
                        state_q  <= CHANGE_PULSE;
                        change_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                CHANGE_PULSE: begin
                    credit_q <= credit_q - 1'b1;
                    if (credit_q == CREDIT_W'(1)) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= CHANGE_GAP;
                        busy_q  <= 1'b1;
                    end
                end
                CHANGE_GAP: begin
                    state_q  <= CHANGE_PULSE;
                    change_q <= 1'b1;
                    busy_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.vend   = vend_q;
    assign bus.change = change_q;
    assign bus.credit = credit_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - directed self-checking bench for vend_controller
module tb_vend_controller;
    localparam int NP = 2;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    vend_if #(.NUM_PRODUCTS(NP), .CREDIT_W(CW)) bus ();

    vend_controller #(.NUM_PRODUCTS(NP), .PRICE(9), .CREDIT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int units);
        bus.nickel  = (units == 1);
        bus.dime    = (units == 2);
        bus.quarter = (units == 5);
        repeat (3) tick();
        bus.nickel  = 1'b0;
        bus.dime    = 1'b0;
        bus.quarter = 1'b0;
        repeat (2) tick();
    endtask

    // Observes from the cycle right after the triggering edge (index 1) until busy drops.
    task automatic watch(output int pulses, output int first, output int last,
                         output int vends, output int overlap);
        int idx;
        bit done;
        pulses = 0; first = -1; last = -1; vends = 0; overlap = 0;
        idx = 1;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (bus.change) begin
                pulses++;
                if (first < 0) first = idx;
                last = idx;
            end
            if (bus.vend != '0) vends++;
            if (bus.vend != '0 && bus.change) overlap++;
            if (!bus.busy) done = 1'b1;
            else begin
                tick();
                idx++;
            end
        end
        if (!done) check_eq("watch_timeout", 0, 1);
    endtask

    task automatic buy(input string tag, input logic [NP-1:0] sel, input int exp_pulses);
        int p, f, l, v, o;
        bus.select = sel;
        tick();
        bus.select = '0;
        check_eq({tag, "_vend"}, int'(bus.vend), int'(sel));
        watch(p, f, l, v, o);
        check_eq({tag, "_pulses"}, p, exp_pulses);
        check_eq({tag, "_vends"}, v, 1);
        check_eq({tag, "_overlap"}, o, 0);
        if (exp_pulses > 0) begin
            check_eq({tag, "_first"}, f, 2);
            check_eq({tag, "_last"}, l, 2 * exp_pulses);
        end
        check_eq({tag, "_credit"}, int'(bus.credit), 0);
    endtask

    task automatic refund(input string tag, input logic [NP-1:0] sel, input int exp_pulses);
        int p, f, l, v, o;
        bus.cancel = 1'b1;
        bus.select = sel;
        tick();
        bus.cancel = 1'b0;
        bus.select = '0;
        watch(p, f, l, v, o);
        check_eq({tag, "_pulses"}, p, exp_pulses);
        check_eq({tag, "_first"}, f, 1);
        check_eq({tag, "_last"}, l, 2 * exp_pulses - 1);
        check_eq({tag, "_vends"}, v, 0);
        check_eq({tag, "_credit"}, int'(bus.credit), 0);
    endtask

    initial begin
        reset       = 1'b1;
        bus.nickel  = 1'b0;
        bus.dime    = 1'b0;
        bus.quarter = 1'b0;
        bus.select  = '0;
        bus.cancel  = 1'b0;
        repeat (2) tick();
        check_eq("rst_credit", int'(bus.credit), 0);
        check_eq("rst_vend", int'(bus.vend), 0);
        check_eq("rst_change", int'(bus.change), 0);
        check_eq("rst_busy", int'(bus.busy), 0);
        reset = 1'b0;
        tick();

        // Q, D, D then exact-price purchase
        coin(5); check_eq("t1_q", int'(bus.credit), 5);
        coin(2); check_eq("t1_d1", int'(bus.credit), 7);
        coin(2); check_eq("t1_d2", int'(bus.credit), 9);
        buy("t1_buy", 2'b01, 0);

        // Q, Q overshoots; further coin rejected
        coin(5); check_eq("t2_q1", int'(bus.credit), 5);
        coin(5); check_eq("t2_q2", int'(bus.credit), 10);
        coin(2); check_eq("t2_d_ignored", int'(bus.credit), 10);
        buy("t2_buy", 2'b10, 1);

        // D, D, Q, ignored Q, buy; then D, Q, Q with 3 nickels change
        coin(2); check_eq("t3_d1", int'(bus.credit), 2);
        coin(2); check_eq("t3_d2", int'(bus.credit), 4);
        coin(5); check_eq("t3_q", int'(bus.credit), 9);
        coin(5); check_eq("t3_q_ignored", int'(bus.credit), 9);
        buy("t3_buy", 2'b01, 0);
        coin(2); check_eq("t3b_d", int'(bus.credit), 2);
        coin(5); check_eq("t3b_q1", int'(bus.credit), 7);
        coin(5); check_eq("t3b_q2", int'(bus.credit), 12);
        buy("t3b_buy", 2'b10, 3);

        // Nickel held 10 cycles credits once; two lines together credit nothing
        bus.nickel = 1'b1;
        repeat (10) tick();
        bus.nickel = 1'b0;
        repeat (2) tick();
        check_eq("t4_held_n", int'(bus.credit), 1);
        bus.nickel = 1'b1;
        bus.dime   = 1'b1;
        repeat (3) tick();
        bus.dime   = 1'b0;
        repeat (3) tick();
        check_eq("t4_jam_partial", int'(bus.credit), 1);
        bus.nickel = 1'b0;
        repeat (2) tick();
        check_eq("t4_jam_release", int'(bus.credit), 1);
        coin(2); check_eq("t4_after_jam", int'(bus.credit), 3);
        refund("t4_refund", 2'b00, 3);

        // Cancel at zero credit does nothing
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check_eq("t5_cancel0_change", int'(bus.change), 0);
        check_eq("t5_cancel0_busy", int'(bus.busy), 0);

        // Q then cancel; cancel beats select at full credit
        coin(5);
        refund("t5_refund_q", 2'b00, 5);
        coin(2); coin(2); coin(5);
        check_eq("t5_credit9", int'(bus.credit), 9);
        refund("t5_cancel_sel", 2'b01, 9);

        // Reset during second change pulse
        coin(2); coin(5); coin(5);
        check_eq("t6_credit12", int'(bus.credit), 12);
        bus.select = 2'b01;
        tick();
        bus.select = '0;
        check_eq("t6_vend", int'(bus.vend), 1);
        tick();
        check_eq("t6_pulse1", int'(bus.change), 1);
        tick();
        check_eq("t6_gap", int'(bus.change), 0);
        tick();
        check_eq("t6_pulse2", int'(bus.change), 1);
        check_eq("t6_credit_mid", int'(bus.credit), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t6_rst_credit", int'(bus.credit), 0);
        check_eq("t6_rst_change", int'(bus.change), 0);
        check_eq("t6_rst_vend", int'(bus.vend), 0);
        check_eq("t6_rst_busy", int'(bus.busy), 0);
        tick();
        check_eq("t6_idle_change", int'(bus.change), 0);

        // Multi-hot select ignored
        coin(2); coin(2); coin(5);
        bus.select = 2'b11;
        tick();
        bus.select = '0;
        check_eq("t7_multihot_vend", int'(bus.vend), 0);
        check_eq("t7_multihot_busy", int'(bus.busy), 0);
        check_eq("t7_multihot_credit", int'(bus.credit), 9);
        buy("t7_buy", 2'b10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
